// File: rtl/hex_reader.sv
// Monitors a multiplexed active-low 7-segment bus, decodes each stable digit
// pattern back to its value and reports new/changed digits on a 1-deep stream.
module hex_reader #(
   parameter int NDIG          = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic [6:0]              HEX,
   input  logic [NDIG-1:0]         DIG_SEL,
   input  logic                    out_ready,
   input  logic                    clr_overrun,
   output logic                    out_valid,
   output logic [$clog2(NDIG)-1:0] out_digit,
   output logic [3:0]              out_val,
   output logic                    out_err,
   output logic                    overrun,
   output logic [4*NDIG-1:0]       digits
);

   localparam int IW = $clog2(NDIG);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

   // Returns {err, val}; blank (all segments off) reads as 0.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      case (seg)
         7'h7F:   decode = {1'b0, 4'h0};
         7'h79:   decode = {1'b0, 4'h1};
         7'h24:   decode = {1'b0, 4'h2};
         7'h30:   decode = {1'b0, 4'h3};
         7'h19:   decode = {1'b0, 4'h4};
         7'h12:   decode = {1'b0, 4'h5};
         7'h02:   decode = {1'b0, 4'h6};
         7'h78:   decode = {1'b0, 4'h7};
         7'h00:   decode = {1'b0, 4'h8};
         7'h10:   decode = {1'b0, 4'h9};
         default: decode = {1'b1, 4'hF};
      endcase
   endfunction

   function automatic logic is_onehot(input logic [NDIG-1:0] v);
      is_onehot = (v != '0) && ((v & (v - NDIG'(1))) == '0);
   endfunction

   function automatic logic [IW-1:0] sel_index(input logic [NDIG-1:0] v);
      sel_index = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (v[i]) sel_index = IW'(i);
      end
   endfunction

   logic [6:0]       s_hex_q, p_hex_q;
   logic [NDIG-1:0]  s_sel_q, p_sel_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [4*NDIG-1:0] digits_q, digits_d;
   logic [NDIG-1:0]  seen_q, seen_d;
   logic             out_valid_q, out_valid_d;
   logic [IW-1:0]    out_digit_q, out_digit_d;
   logic [3:0]       out_val_q, out_val_d;
   logic             out_err_q, out_err_d;
   logic             overrun_q, overrun_d;

   logic             onehot, same, capture, changed, event_v, load_ok;
   logic [IW-1:0]    idx;
   logic [4:0]       dec;
   logic [3:0]       old_val;

   always_comb begin
      onehot  = is_onehot(s_sel_q);
      same    = (s_hex_q == p_hex_q) && (s_sel_q == p_sel_q);
      idx     = sel_index(s_sel_q);
      dec     = decode(s_hex_q);
      old_val = digits_q[{idx, 2'b00} +: 4];

      if (!onehot) begin
         cnt_d = '0;
      end else if (same) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      end else begin
         cnt_d = CW'(1);
      end

      // Fires on the single cycle the run length reaches the threshold.
      capture = onehot && same && (cnt_q == CNT_MAX - CW'(1));
      changed = !seen_q[idx] || (dec[3:0] != old_val);
      event_v = capture && (dec[4] || changed);
      load_ok = !out_valid_q || out_ready;

      digits_d = digits_q;
      seen_d   = seen_q;
      if (capture && !dec[4] && changed) begin
         digits_d[{idx, 2'b00} +: 4] = dec[3:0];
         seen_d[idx]                 = 1'b1;
      end else begin
         seen_d = seen_q;
      end

      out_valid_d = out_valid_q;
      out_digit_d = out_digit_q;
      out_val_d   = out_val_q;
      out_err_d   = out_err_q;
      if (event_v && load_ok) begin
         out_valid_d = 1'b1;
         out_digit_d = idx;
         out_val_d   = dec[3:0];
         out_err_d   = dec[4];
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (event_v && !load_ok) begin
         overrun_d = 1'b1;
      end else if (clr_overrun) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s_hex_q     <= 7'h00;
         s_sel_q     <= '0;
         p_hex_q     <= 7'h00;
         p_sel_q     <= '0;
         cnt_q       <= '0;
         digits_q    <= '0;
         seen_q      <= '0;
         out_valid_q <= 1'b0;
         out_digit_q <= '0;
         out_val_q   <= 4'h0;
         out_err_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         s_hex_q     <= HEX;
         s_sel_q     <= DIG_SEL;
         p_hex_q     <= s_hex_q;
         p_sel_q     <= s_sel_q;
         cnt_q       <= cnt_d;
         digits_q    <= digits_d;
         seen_q      <= seen_d;
         out_valid_q <= out_valid_d;
         out_digit_q <= out_digit_d;
         out_val_q   <= out_val_d;
         out_err_q   <= out_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_digit = out_digit_q;
   assign out_val   = out_val_q;
   assign out_err   = out_err_q;
   assign overrun   = overrun_q;
   assign digits    = digits_q;

endmodule

// File: tb/tb_hex_reader.sv
// Directed bench for hex_reader: expected events are queued as stimulus is
// driven and checked by a monitor on each output handshake.
module tb_hex_reader;

   localparam int NDIG   = 4;
   localparam int STABLE = 8;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [6:0]  HEX;
   logic [3:0]  DIG_SEL;
   logic        out_ready;
   logic        clr_overrun;
   logic        out_valid;
   logic [1:0]  out_digit;
   logic [3:0]  out_val;
   logic        out_err;
   logic        overrun;
   logic [15:0] digits;

   int passed = 0;
   int total  = 0;
   logic [6:0] sb[$];   // {digit, val, err}

   logic [6:0] code_tab [10] = '{7'h7F, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   logic [3:0] exp_dig [4];
   logic       exp_seen [4];

   hex_reader #(.NDIG(NDIG), .STABLE_CYCLES(STABLE)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .HEX(HEX), .DIG_SEL(DIG_SEL),
      .out_ready(out_ready), .clr_overrun(clr_overrun),
      .out_valid(out_valid), .out_digit(out_digit), .out_val(out_val),
      .out_err(out_err), .overrun(overrun), .digits(digits)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"},   32'(out_valid), 32'd0);
      check({tag, "_digit"},   32'(out_digit), 32'd0);
      check({tag, "_val"},     32'(out_val),   32'd0);
      check({tag, "_err"},     32'(out_err),   32'd0);
      check({tag, "_overrun"}, 32'(overrun),   32'd0);
      check({tag, "_digits"},  32'(digits),    32'd0);
   endtask

   // Scoreboard: every accepted output event must match the oldest queued one.
   always @(negedge Clk) begin : monitor
      logic [6:0] e;
      if (Reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         check("evt_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("evt_digit", 32'(out_digit), 32'(e[6:5]));
            check("evt_val",   32'(out_val),   32'(e[4:1]));
            check("evt_err",   32'(out_err),   32'(e[0]));
         end
      end
   end

   initial begin
      HEX = 7'h00; DIG_SEL = 4'b0000; out_ready = 1'b1; clr_overrun = 1'b0;
      Reset_n = 1'b0;

      // 1: reset with random inputs, then idle after release
      repeat (6) begin
         @(posedge Clk); #1;
         HEX = 7'($urandom); DIG_SEL = 4'($urandom);
         out_ready = 1'($urandom); clr_overrun = 1'($urandom);
      end
      check_idle("rst");
      HEX = 7'h00; DIG_SEL = 4'b0000; out_ready = 1'b1; clr_overrun = 1'b0;
      Reset_n = 1'b1;
      tick(5);
      check_idle("post_rst");

      // 2: digit 1 = 2, with exact capture latency
      HEX = 7'h24; DIG_SEL = 4'b0010;
      sb.push_back({2'd1, 4'h2, 1'b0});
      repeat (STABLE) @(posedge Clk);
      @(negedge Clk);
      check("lat_early_valid", 32'(out_valid), 32'd0);
      @(posedge Clk);
      @(negedge Clk);
      check("lat_valid",  32'(out_valid), 32'd1);
      check("lat_digits", 32'(digits),    32'h0020);
      @(posedge Clk); #1;
      tick(10);
      check("t2_single",  32'(out_valid), 32'd0);
      check("t2_sb",      32'(sb.size()), 32'd0);
      check("t2_digits",  32'(digits),    32'h0020);

      // 3: short run of 2 then switch to 3
      DIG_SEL = 4'b0000;
      tick(3);
      HEX = 7'h24; DIG_SEL = 4'b0010;
      tick(5);
      HEX = 7'h30;
      sb.push_back({2'd1, 4'h3, 1'b0});
      tick(STABLE + 6);
      check("t3_sb",     32'(sb.size()), 32'd0);
      check("t3_digits", 32'(digits),    32'h0030);

      // 4: invalid pattern
      HEX = 7'h7E; DIG_SEL = 4'b0001;
      sb.push_back({2'd0, 4'hF, 1'b1});
      tick(STABLE + 4);
      check("t4_sb",     32'(sb.size()), 32'd0);
      check("t4_digits", 32'(digits),    32'h0030);

      // 5: backpressure, overrun and clear
      Reset_n = 1'b0;
      tick(2);
      Reset_n = 1'b1;
      out_ready = 1'b0;
      HEX = 7'h12; DIG_SEL = 4'b0100;
      sb.push_back({2'd2, 4'h5, 1'b0});
      tick(STABLE + 4);
      HEX = 7'h10; DIG_SEL = 4'b1000;
      tick(STABLE + 4);
      check("t5_valid",   32'(out_valid), 32'd1);
      check("t5_digit",   32'(out_digit), 32'd2);
      check("t5_val",     32'(out_val),   32'h5);
      check("t5_err",     32'(out_err),   32'd0);
      check("t5_overrun", 32'(overrun),   32'd1);
      check("t5_digits",  32'(digits),    32'h9500);
      clr_overrun = 1'b1;
      tick(1);
      clr_overrun = 1'b0;
      tick(1);
      check("t5_clr",      32'(overrun),   32'd0);
      check("t5_held",     32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick(2);
      check("t5_drain",    32'(out_valid), 32'd0);
      check("t5_sb",       32'(sb.size()), 32'd0);

      // 6: round-robin sweep of all codes, then an invalid select
      exp_dig  = '{4'h0, 4'h0, 4'h5, 4'h9};
      exp_seen = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 11; k++) begin
         int d;
         int v;
         v = (k < 10) ? k : 8;
         d = (k < 10) ? (k % 4) : 0;
         HEX = code_tab[v];
         DIG_SEL = 4'(1 << d);
         if (!exp_seen[d] || exp_dig[d] != 4'(v))
            sb.push_back({2'(d), 4'(v), 1'b0});
         exp_dig[d]  = 4'(v);
         exp_seen[d] = 1'b1;
         tick(STABLE + 4);
      end
      check("t6_sb",     32'(sb.size()), 32'd0);
      check("t6_digits", 32'(digits),
            32'({exp_dig[3], exp_dig[2], exp_dig[1], exp_dig[0]}));
      HEX = 7'h24; DIG_SEL = 4'b0011;
      tick(STABLE * 2);
      check("t6_multi_cnt",   32'(dut.cnt_q), 32'd0);
      check("t6_multi_valid", 32'(out_valid), 32'd0);
      check("t6_multi_sb",    32'(sb.size()), 32'd0);
      check("t6_multi_digits", 32'(digits),   32'h7698);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
